// File: rtl/ramchk.sv
// rtl/ramchk.sv - RAM controller exerciser: per pass, writes a pattern on the data port,
// then reads it back on the data port and on the instruction port, counting miscompares.
module ramchk #(
  parameter int AW     = 25,
  parameter int DW     = 128,
  parameter int NWORDS = 1024,
  parameter int PASSES = 2,
  parameter int TMO    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          inst_stb,
  output logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_din,
  input  logic          inst_ack,
  output logic          data_stb,
  output logic          data_we,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_dout,
  input  logic [DW-1:0] data_din,
  input  logic          data_ack,
  output logic          test_ended,
  output logic          test_error,
  output logic          tmo_abort,
  output logic [7:0]    err_count,
  output logic [AW-1:0] err_addr
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RDD, S_RDI, S_NEXT, S_DONE} state_t;

  localparam logic [AW-1:0] LAST    = AW'(NWORDS - 1);
  localparam logic [31:0]   TMO_TC  = 32'(TMO - 1);
  localparam logic [31:0]   NPASSES = 32'(PASSES);

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [31:0]   p_q, p_d;
  logic [31:0]   tmo_q, tmo_d;
  logic          dstb_q, dstb_d, istb_q, istb_d, we_q, we_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          ended_q, ended_d, error_q, error_d, abort_q, abort_d;
  logic [7:0]    ecnt_q, ecnt_d;
  logic [AW-1:0] eaddr_q, eaddr_d;

  // Lane i carries the address, inverted on odd passes, XORed with i replicated per byte.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic odd);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) begin
      v[32*i +: 32] = 32'(a) ^ {32{odd}} ^ (32'(i) * 32'h0101_0101);
    end
    return v;
  endfunction

  logic          stb, ack;
  logic [DW-1:0] rdata;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    tmo_d   = tmo_q;
    dstb_d  = dstb_q;
    istb_d  = istb_q;
    we_d    = we_q;
    dout_d  = dout_q;
    ended_d = ended_q;
    error_d = error_q;
    abort_d = abort_q;
    ecnt_d  = ecnt_q;
    eaddr_d = eaddr_q;

    stb   = dstb_q | istb_q;
    // Only the channel whose strobe is up can complete a request.
    ack   = (dstb_q & data_ack) | (istb_q & inst_ack);
    rdata = istb_q ? inst_din : data_din;

    if (stb && !ack) tmo_d = tmo_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        state_d = S_WR;
        a_d     = '0;
        p_d     = '0;
        tmo_d   = '0;
        dstb_d  = 1'b1;
        we_d    = 1'b1;
        dout_d  = pat('0, 1'b0);
      end
      S_WR, S_RDD, S_RDI: begin
        if (!stb) begin
          tmo_d = '0;
          if (state_q == S_RDI) begin
            istb_d = 1'b1;
          end else begin
            dstb_d = 1'b1;
            we_d   = (state_q == S_WR);
          end
          if (state_q == S_WR) dout_d = pat(a_q, p_q[0]);
        end else if (ack) begin
          dstb_d = 1'b0;
          istb_d = 1'b0;
          we_d   = 1'b0;
          if (state_q != S_WR && rdata != pat(a_q, p_q[0])) begin
            error_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            if (ecnt_q == 8'd0)  eaddr_d = a_q;
          end
          if (a_q == LAST) begin
            a_d = '0;
            case (state_q)
              S_WR:    state_d = S_RDD;
              S_RDD:   state_d = S_RDI;
              default: state_d = S_NEXT;
            endcase
          end else begin
            a_d = a_q + 1'b1;
          end
        end else if (tmo_q == TMO_TC) begin
          dstb_d  = 1'b0;
          istb_d  = 1'b0;
          we_d    = 1'b0;
          abort_d = 1'b1;
          error_d = 1'b1;
          if (ecnt_q == 8'd0) eaddr_d = a_q;
          ended_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_NEXT: begin
        p_d = p_q + 32'd1;
        if (p_q + 32'd1 == NPASSES) begin
          ended_d = 1'b1;
          state_d = S_DONE;
        end else begin
          // Raise the first write strobe here so the pass boundary costs one idle cycle.
          state_d = S_WR;
          a_d     = '0;
          tmo_d   = '0;
          dstb_d  = 1'b1;
          we_d    = 1'b1;
          dout_d  = pat('0, ~p_q[0]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      p_q     <= '0;
      tmo_q   <= '0;
      dstb_q  <= 1'b0;
      istb_q  <= 1'b0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      ended_q <= 1'b0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
      ecnt_q  <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      tmo_q   <= tmo_d;
      dstb_q  <= dstb_d;
      istb_q  <= istb_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      ended_q <= ended_d;
      error_q <= error_d;
      abort_q <= abort_d;
      ecnt_q  <= ecnt_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign inst_stb   = istb_q;
  assign inst_addr  = a_q;
  assign data_stb   = dstb_q;
  assign data_we    = we_q;
  assign data_addr  = a_q;
  assign data_dout  = dout_q;
  assign test_ended = ended_q;
  assign test_error = error_q;
  assign tmo_abort  = abort_q;
  assign err_count  = ecnt_q;
  assign err_addr   = eaddr_q;

endmodule

// File: tb/tb_ramchk.sv
// tb/tb_ramchk.sv - scoreboard bench for ramchk: memory/responder model with random latency,
// spurious acks, injected corruption, hung requests and mid-transfer reset.
module tb_ramchk;
  localparam int AW = 8, DW = 128, NW = 16, NP = 8, TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_stb, inst_ack, data_stb, data_we, data_ack;
  logic [AW-1:0] inst_addr, data_addr, err_addr;
  logic [DW-1:0] inst_din, data_din, data_dout;
  logic          test_ended, test_error, tmo_abort;
  logic [7:0]    err_count;

  ramchk #(.AW(AW), .DW(DW), .NWORDS(NW), .PASSES(NP), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_stb(inst_stb), .inst_addr(inst_addr), .inst_din(inst_din), .inst_ack(inst_ack),
    .data_stb(data_stb), .data_we(data_we), .data_addr(data_addr), .data_dout(data_dout),
    .data_din(data_din), .data_ack(data_ack),
    .test_ended(test_ended), .test_error(test_error), .tmo_abort(tmo_abort),
    .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int addr; int pass; logic [DW-1:0] data;} req_t;
  req_t q[$];

  int checks = 0, failures = 0;
  int lat_min, lat_max, spur, flip_a, flip_all, hang_a;
  logic [DW-1:0] mem [256];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a, input int p);
    logic [DW-1:0] v;
    logic [31:0] l;
    for (int i = 0; i < DW / 32; i++) begin
      l = 32'(a);
      if (p % 2 == 1) l = ~l;
      l = l ^ 32'(i * 32'h0101_0101);
      v[32*i +: 32] = l;
    end
    return v;
  endfunction

  // Monitor (scoreboard pop) and memory responder share the falling edge, monitor first.
  int cyc = 0, last_ack_cyc = 0, lo_cnt = 0, hi_cnt = 0, last_hi = 0, post_strobe = 0;
  int dcnt = 0, icnt = 0, dlat = 1, ilat = 1;
  bit dprev = 0, iprev = 0, first = 1, ended_prev = 0;
  initial begin
    req_t e;
    int   kind, addr;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        dprev = 0; iprev = 0; first = 1; ended_prev = 0; lo_cnt = 0; hi_cnt = 0;
        last_hi = 0; post_strobe = 0; dcnt = 0; icnt = 0;
        data_ack = 0; inst_ack = 0;
        continue;
      end
      if (test_ended && (data_stb || inst_stb)) post_strobe++;
      if ((data_stb && !dprev) || (inst_stb && !iprev)) begin
        if (!first) chk("idle_gap", DW'(lo_cnt), DW'(1));
        first = 0;
        chk("one_strobe", DW'(data_stb & inst_stb), '0);
        kind = inst_stb ? 2 : (data_we ? 0 : 1);
        addr = inst_stb ? int'(inst_addr) : int'(data_addr);
        if (q.size() == 0) begin
          chk("unexpected_request", DW'(kind), DW'(99));
        end else begin
          e = q.pop_front();
          chk("req_kind", DW'(kind), DW'(e.kind));
          chk("req_addr", DW'(addr), DW'(e.addr));
          if (e.kind == 0) chk("write_data", data_dout, e.data);
          if (e.kind == 0 && e.addr == 3 && e.pass == 1)
            chk("lanes_a3_p1", DW'(data_dout[63:0]), DW'(64'hFEFEFEFD_FFFFFFFC));
        end
      end
      if (data_stb || inst_stb) begin
        hi_cnt++; lo_cnt = 0;
      end else begin
        if (hi_cnt != 0) last_hi = hi_cnt;
        hi_cnt = 0; lo_cnt++;
      end
      if (test_ended && !ended_prev && hang_a < 0)
        chk("ended_latency", DW'(cyc - last_ack_cyc), DW'(2));
      ended_prev = test_ended;
      dprev = data_stb; iprev = inst_stb;

      if (data_stb) begin
        dcnt++;
        data_ack = 0;
        if (dcnt == dlat && !(data_we && int'(data_addr) == hang_a)) begin
          data_ack = 1;
          last_ack_cyc = cyc;
          if (data_we) mem[data_addr] = data_dout;
          else begin
            data_din = mem[data_addr];
            if (flip_all != 0 || int'(data_addr) == flip_a) data_din[0] = ~data_din[0];
          end
        end
      end else begin
        dcnt = 0;
        dlat = $urandom_range(lat_max, lat_min);
        data_ack = (spur != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        data_din = {$urandom, $urandom, $urandom, $urandom};
      end
      if (inst_stb) begin
        icnt++;
        inst_ack = 0;
        if (icnt == ilat) begin
          inst_ack = 1;
          last_ack_cyc = cyc;
          inst_din = mem[inst_addr];
          if (flip_all != 0) inst_din[5] = ~inst_din[5];
        end
      end else begin
        icnt = 0;
        ilat = $urandom_range(lat_max, lat_min);
        inst_ack = (spur != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        inst_din = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic start(input int lmin, input int lmax, input int sp, input int fa,
                       input int fall, input int ha);
    rst_n = 1'b0;
    #1;
    chk("reset_ctrl", DW'({inst_stb, inst_addr, data_stb, data_we, data_addr, test_ended,
                           test_error, tmo_abort, err_count, err_addr}), '0);
    chk("reset_dout", data_dout, '0);
    lat_min = lmin; lat_max = lmax; spur = sp; flip_a = fa; flip_all = fall; hang_a = ha;
    q.delete();
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < NW; a++) begin
        if (ha < 0 || a <= ha) q.push_back('{0, a, p, pat(a, p)});
      end
      if (ha >= 0) break;
      for (int a = 0; a < NW; a++) q.push_back('{1, a, p, '0});
      for (int a = 0; a < NW; a++) q.push_back('{2, a, p, '0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic finish_run(input int exp_cnt, input int exp_ea, input int exp_abort);
    int n = 0;
    while (!test_ended && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("test_ended", DW'(test_ended), DW'(1));
    repeat (5) @(negedge clk);
    chk("test_error", DW'(test_error), DW'((exp_cnt != 0 || exp_abort != 0) ? 1 : 0));
    chk("tmo_abort", DW'(tmo_abort), DW'(exp_abort));
    chk("err_count", DW'(err_count), DW'(exp_cnt));
    chk("err_addr", DW'(err_addr), DW'(exp_ea));
    chk("queue_drained", DW'(q.size()), '0);
    chk("no_strobe_after_end", DW'(post_strobe), '0);
  endtask

  task automatic run(input int lmin, input int lmax, input int sp, input int fa, input int fall,
                     input int ha, input int exp_cnt, input int exp_ea, input int exp_abort);
    start(lmin, lmax, sp, fa, fall, ha);
    finish_run(exp_cnt, exp_ea, exp_abort);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; data_ack = 0; inst_ack = 0; data_din = '0; inst_din = '0;
    hang_a = -1;
    repeat (2) @(negedge clk);

    run(1, 1, 0, -1, 0, -1, 0, 0, 0);
    run(1, 4, 1, -1, 0, -1, 0, 0, 0);
    run(1, 3, 0, 5, 0, -1, NP, 5, 0);
    run(1, 2, 1, -1, 1, -1, 255, 0, 0);
    run(TMO, TMO, 1, -1, 0, -1, 0, 0, 0);
    run(1, 2, 0, -1, 0, 7, 0, 7, 1);
    chk("hung_strobe_cycles", DW'(last_hi), DW'(TMO));

    start(1, 3, 1, -1, 0, -1);
    n = 0;
    while (!(data_stb && !data_we) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rdd", DW'(data_stb && !data_we), DW'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", DW'({data_stb, inst_stb, data_we, data_addr}), '0);
    @(negedge clk);
    run(1, 3, 1, -1, 0, -1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
